// File: rtl/arb2to1_ctrl.sv
// Two-requester round-robin arbiter with a one-entry registered output stage.
// sel drives the external 2:1 data mux (1 = A, 0 = B); y_* holds the winning beat.
// Optional feature: define ARB2_LOCK_EN to make bursts (terminated by *_last) atomic.
module arb2to1_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             sel,
   output logic             y_valid,
   output logic [WIDTH-1:0] y_data,
   output logic             y_src,
   input  logic             y_ready
);

   typedef enum logic [1:0] {StFree, StLockA, StLockB} state_e;

   state_e           state_q, state_d;
   logic             prio_q, prio_d;     // 1 = A has priority on a tie
   logic             y_valid_q, y_valid_d;
   logic [WIDTH-1:0] y_data_q, y_data_d;
   logic             y_src_q, y_src_d;
   logic             load, req_a, req_b, gnt_a, gnt_b;

   // Grant decode: output register can take a beat when empty or being drained.
   always_comb begin
      load  = !y_valid_q | y_ready;
      req_a = 1'b0;
      req_b = 1'b0;
      unique case (state_q)
         StLockA: req_a = a_valid;
         StLockB: req_b = b_valid;
         default: begin
            req_a = a_valid & (!b_valid | prio_q);
            req_b = b_valid & (!a_valid | !prio_q);
         end
      endcase
      gnt_a   = load & req_a;
      gnt_b   = load & req_b;
      a_ready = gnt_a;
      b_ready = gnt_b;
      // With no grant the select parks on the priority holder.
      sel     = gnt_a ? 1'b1 : (gnt_b ? 1'b0 : prio_q);
   end

   // Next-state for lock FSM, round-robin pointer and output register.
`ifdef ARB2_LOCK_EN
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      if (gnt_a) begin
         if (a_last) begin
            state_d = StFree;
            prio_d  = 1'b0;
         end else begin
            state_d = StLockA;
         end
      end else if (gnt_b) begin
         if (b_last) begin
            state_d = StFree;
            prio_d  = 1'b1;
         end else begin
            state_d = StLockB;
         end
      end
   end
`else
   logic unused_last;
   assign unused_last = a_last ^ b_last;

   always_comb begin
      state_d = StFree;
      prio_d  = prio_q;
      if (gnt_a) begin
         prio_d = 1'b0;
      end else if (gnt_b) begin
         prio_d = 1'b1;
      end
   end
`endif

   // Output register next-state: refill on grant, empty when loading without grant.
   always_comb begin
      y_valid_d = y_valid_q;
      y_data_d  = y_data_q;
      y_src_d   = y_src_q;
      if (load) begin
         y_valid_d = gnt_a | gnt_b;
      end
      if (gnt_a | gnt_b) begin
         y_data_d = sel ? a_data : b_data;
         y_src_d  = sel;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFree;
         prio_q    <= 1'b1;
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_src_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         y_valid_q <= y_valid_d;
         y_data_q  <= y_data_d;
         y_src_q   <= y_src_d;
      end
   end

   assign y_valid = y_valid_q;
   assign y_data  = y_data_q;
   assign y_src   = y_src_q;

endmodule

// File: tb/tb_arb2to1_ctrl.sv
// Self-checking bench for arb2to1_ctrl: a reference arbiter model predicts grants
// and pushes expected beats into a scoreboard queue checked against y_*.
module tb_arb2to1_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             a_valid, a_last, a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid, b_last, b_ready;
   logic [WIDTH-1:0] b_data;
   logic             sel, y_valid, y_src, y_ready;
   logic [WIDTH-1:0] y_data;

   typedef struct packed {
      logic             src;
      logic [WIDTH-1:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks;
   int    n_errors;
   logic  m_prio;      // 1 = A
   int    m_state;     // 0 free, 1 lock A, 2 lock B
   logic  m_acc_a, m_acc_b;

   arb2to1_ctrl #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_valid (a_valid),
      .a_data  (a_data),
      .a_last  (a_last),
      .a_ready (a_ready),
      .b_valid (b_valid),
      .b_data  (b_data),
      .b_last  (b_last),
      .b_ready (b_ready),
      .sel     (sel),
      .y_valid (y_valid),
      .y_data  (y_data),
      .y_src   (y_src),
      .y_ready (y_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_prio  = 1'b1;
      m_state = 0;
      m_acc_a = 1'b0;
      m_acc_b = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, advance the model, return after rising edge.
   task automatic step();
      logic  load, ga, gb, esel;
      beat_t bt;
      @(negedge clk);
      load = (exp_q.size() == 0) || y_ready;
      check_eq("y_valid", y_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check_eq("y_data", y_data, exp_q[0].data);
         check_eq("y_src", y_src, exp_q[0].src);
      end
      ga = 1'b0;
      gb = 1'b0;
      if (load) begin
         if (m_state == 1) ga = a_valid;
         else if (m_state == 2) gb = b_valid;
         else if (a_valid && b_valid) begin
            ga = m_prio;
            gb = !m_prio;
         end else begin
            ga = a_valid;
            gb = b_valid;
         end
      end
      esel = ga ? 1'b1 : (gb ? 1'b0 : m_prio);
      check_eq("a_ready", a_ready, ga);
      check_eq("b_ready", b_ready, gb);
      check_eq("sel", sel, esel);
      if (load && exp_q.size() != 0) void'(exp_q.pop_front());
      if (ga || gb) begin
         bt.src  = ga;
         bt.data = ga ? a_data : b_data;
         exp_q.push_back(bt);
      end
`ifdef ARB2_LOCK_EN
      if (ga) begin
         if (a_last) begin m_state = 0; m_prio = 1'b0; end
         else m_state = 1;
      end else if (gb) begin
         if (b_last) begin m_state = 0; m_prio = 1'b1; end
         else m_state = 2;
      end
`else
      if (ga) m_prio = 1'b0;
      else if (gb) m_prio = 1'b1;
`endif
      m_acc_a = ga;
      m_acc_b = gb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a_sent;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      rst_n   = 1'b0;
      a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      b_valid = 1'b0; b_data = '0; b_last = 1'b0;
      y_ready = 1'b1;

      // Reset values
      #2;
      check_eq("rst_y_valid", y_valid, 0);
      check_eq("rst_y_data", y_data, 0);
      check_eq("rst_y_src", y_src, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

      // Asynchronous reset in the middle of a stalled transfer
      a_valid = 1'b1; a_data = 8'h33; y_ready = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_y_valid", y_valid, 0);
      check_eq("async_y_data", y_data, 0);
      check_eq("async_y_src", y_src, 0);
      model_reset();
      a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; y_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #2;
      check_eq("tie_after_rst", sel, 1);
      step();

      // Both requesters held: alternating beats, one per clock
      for (int i = 0; i < 8; i++) step();

      // Only B valid
      a_valid = 1'b0; b_data = 8'h5A;
      step();
      b_valid = 1'b0;
      step();

      // Consumer stall with both requesters valid
      a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b1; b_data = 8'hC3;
      step();
      y_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      y_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // Three-beat A burst against a continuously valid B
      a_valid = 1'b0; b_valid = 1'b0;
      step();
      step();
      a_sent = 0;
      a_valid = 1'b1; a_data = 8'hA0; a_last = 1'b0;
      b_valid = 1'b1; b_data = 8'h77; b_last = 1'b1;
      for (int i = 0; i < 20 && a_sent < 3; i++) begin
         step();
         if (m_acc_a) begin
            a_sent++;
            a_data = 8'hA0 + 8'(a_sent);
            a_last = (a_sent == 2);
         end
      end
      check_eq("burst_done", a_sent, 3);
      a_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      b_valid = 1'b0;

      // Randomised traffic obeying valid/data hold until ready
      for (int i = 0; i < 300; i++) begin
         if (!a_valid || m_acc_a) begin
            a_valid = ($urandom_range(0, 2) != 0);
            a_data  = 8'($urandom);
            a_last  = ($urandom_range(0, 2) == 0);
         end
         if (!b_valid || m_acc_b) begin
            b_valid = ($urandom_range(0, 2) != 0);
            b_data  = 8'($urandom);
            b_last  = ($urandom_range(0, 2) == 0);
         end
         y_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Drain
      a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_eq("drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
